lea_data_scan_mac: RTL and testbench

// - Downstream consumer of the tristate LeaData register bank: walks NrOfRegs registers sharing one data bus.
// - Asserts one active-high "cs" deselect line low at a time, samples the shared bus and forms a weighted sum.
// - The weighted sum is sum(data[i] * weight[i]); weights come from an external sync ROM/RAM.
// - Result is handed to the classifier stage over a valid/ready handshake.

---
 rtl/lea_data_scan_mac.sv | 171 +++++++++++++++++
 tb/tb_lea_data_scan_mac.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lea_data_scan_mac.sv
// ============================================================================
// Module      : lea_data_scan_mac
// Description : Scans a bank of tristate LeaData registers sharing one data
//               bus, one register at a time, and accumulates the weighted sum
//               sum(data[i] * weight[i]). Weights come from an external
//               synchronous ROM/RAM. The result goes to the classifier over a
//               valid/ready handshake.
//               Optional macro LEA_SCAN_SATURATE_EN: saturate the accumulator
//               at the signed rails instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lea_data_scan_mac #(
  parameter int NrOfRegs   = 4,
  parameter int NrOfBits   = 8,
  parameter int WeightBits = 8,
  parameter int IdxBits    = 2,
  parameter int AccBits    = 24
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  start,
  output logic                  busy,
  output logic [NrOfRegs-1:0]   cs,
  input  logic [NrOfBits-1:0]   bus_in,
  output logic [IdxBits-1:0]    weight_addr,
  input  logic [WeightBits-1:0] weight_data,
  output logic [AccBits-1:0]    result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int ProdBits = NrOfBits + 1 + WeightBits;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IdxBits-1:0]    idx_q, idx_d;
  logic [AccBits-1:0]    acc_q, acc_d;
  logic [AccBits-1:0]    result_q, result_d;
  logic                  valid_q, valid_d;

  logic [ProdBits-1:0]   data_ext;
  logic [ProdBits-1:0]   weight_ext;
  logic [ProdBits-1:0]   prod;
  logic [AccBits-1:0]    prod_ext;
  logic [AccBits-1:0]    acc_next;

  // Data is unsigned (zero-extend), weight is signed (sign-extend); the
  // product of the two fits exactly in ProdBits, so truncation is lossless.
  assign data_ext   = {{(WeightBits + 1){1'b0}}, bus_in};
  assign weight_ext = {{(NrOfBits + 1){weight_data[WeightBits-1]}}, weight_data};
  assign prod       = data_ext * weight_ext;

  generate
    if (AccBits > ProdBits) begin : g_prod_sext
      assign prod_ext = {{(AccBits - ProdBits){prod[ProdBits-1]}}, prod};
    end else begin : g_prod_same
      assign prod_ext = prod;
    end
  endgenerate

`ifdef LEA_SCAN_SATURATE_EN
  logic [AccBits:0] sum_wide;

  // One guard bit catches signed overflow; clamp to the rail it crossed.
  always_comb begin
    sum_wide = {acc_q[AccBits-1], acc_q} + {prod_ext[AccBits-1], prod_ext};
    if (sum_wide[AccBits] != sum_wide[AccBits-1]) begin
      if (sum_wide[AccBits]) begin
        acc_next = {1'b1, {(AccBits - 1){1'b0}}};
      end else begin
        acc_next = {1'b0, {(AccBits - 1){1'b1}}};
      end
    end else begin
      acc_next = sum_wide[AccBits-1:0];
    end
  end
`else
  // Plain two's-complement add, wrapping modulo 2^AccBits.
  always_comb begin
    acc_next = acc_q + prod_ext;
  end
`endif

  // Deselect lines: exactly one register drives the bus while scanning.
  always_comb begin
    cs = '1;
    if ((state_q == S_SELECT) || (state_q == S_CAPTURE)) begin
      cs[idx_q] = 1'b0;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign weight_addr  = idx_q;
  assign result       = result_q;
  assign result_valid = valid_q;

  // Scan sequencing: next state, index, accumulator and result handoff.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (Tick && start) begin
          state_d = S_SELECT;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_SELECT: begin
        if (Tick) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (Tick) begin
          acc_d = acc_next;
          if (idx_q == IdxBits'(NrOfRegs - 1)) begin
            state_d  = S_DONE;
            result_d = acc_next;
            valid_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IdxBits'(1);
            state_d = S_SELECT;
          end
        end
      end
      S_DONE: begin
        // Handshake completes regardless of Tick.
        if (result_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset that aborts any scan in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lea_data_scan_mac.sv
// ============================================================================
// Module      : tb_lea_data_scan_mac
// Description : Directed self-checking bench for lea_data_scan_mac, with a
//               tristate register-bank model and a registered weight ROM.
//               A second instance with AccBits=17 exercises overflow; its
//               expectation depends on LEA_SCAN_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lea_data_scan_mac;

  logic        Clock;
  logic        Reset;
  logic        Tick;
  logic        start;
  logic        busy;
  logic [3:0]  cs;
  logic [7:0]  bus_in;
  logic [1:0]  weight_addr;
  logic [7:0]  weight_data;
  logic [23:0] result;
  logic        result_valid;
  logic        result_ready;

  logic        start2;
  logic        busy2;
  logic [3:0]  cs2;
  logic [7:0]  bus2;
  logic [1:0]  waddr2;
  logic [7:0]  wdata2;
  logic [16:0] result2;
  logic        valid2;
  logic        ready2;

  logic [7:0]  regs [4];
  logic [7:0]  wts  [4];
  logic [3:0]  cs_exp [8];

  int checks;
  int errors;

  lea_data_scan_mac dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Tick         (Tick),
    .start        (start),
    .busy         (busy),
    .cs           (cs),
    .bus_in       (bus_in),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  lea_data_scan_mac #(.AccBits(17)) dut2 (
    .Clock        (Clock),
    .Reset        (Reset),
    .Tick         (Tick),
    .start        (start2),
    .busy         (busy2),
    .cs           (cs2),
    .bus_in       (bus2),
    .weight_addr  (waddr2),
    .weight_data  (wdata2),
    .result       (result2),
    .result_valid (valid2),
    .result_ready (ready2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register bank: only the register whose cs is low drives the bus.
  always_comb begin
    bus_in = 'z;
    for (int i = 0; i < 4; i++) begin
      if (cs[i] == 1'b0) bus_in = regs[i];
    end
  end

  always_comb begin
    bus2 = 'z;
    for (int i = 0; i < 4; i++) begin
      if (cs2[i] == 1'b0) bus2 = 8'd255;
    end
  end

  // Synchronous weight ROMs.
  always @(posedge Clock) weight_data <= wts[weight_addr];
  always @(posedge Clock) wdata2 <= 8'd127;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_ovf;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    Tick = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    result_ready = 1'b1;
    ready2 = 1'b1;
    cs_exp = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    regs = '{8'd1, 8'd2, 8'd3, 8'd4};
    wts  = '{8'd1, 8'd1, 8'd1, 8'd1};

    // Reset state
    step();
    step();
    check("rst_cs", 32'(cs), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_waddr", 32'(weight_addr), 32'd0);
    Reset = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // T2 basic scan: cs sequence and latency of 9 edges including start edge
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t2_cs", 32'(cs), 32'(cs_exp[k]));
      check("t2_valid_low", 32'(result_valid), 32'd0);
      step();
    end
    check("t2_valid", 32'(result_valid), 32'd1);
    check("t2_result", 32'(result), 32'd10);
    check("t2_done_cs", 32'(cs), 32'hF);
    check("t2_done_busy", 32'(busy), 32'd1);
    step();
    check("t2_idle_valid", 32'(result_valid), 32'd0);
    check("t2_idle_busy", 32'(busy), 32'd0);
    check("t2_idle_result", 32'(result), 32'd10);

    // T1 asynchronous reset in the middle of the second CAPTURE
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("t1_pre_cs", 32'(cs), 32'b1101);
    #1;
    Reset = 1'b1;
    #1;
    check("t1_cs", 32'(cs), 32'hF);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_valid", 32'(result_valid), 32'd0);
    check("t1_result", 32'(result), 32'd0);
    check("t1_acc", 32'(dut.acc_q), 32'd0);
    step();
    Reset = 1'b0;
    step();
    check("t1_post_valid", 32'(result_valid), 32'd0);

    // T3 signed weights; result held with ready low (T5)
    regs = '{8'd255, 8'd0, 8'd10, 8'd1};
    wts  = '{8'hFF, 8'd5, 8'h80, 8'd127};
    result_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("t3_valid", 32'(result_valid), 32'd1);
    check("t3_result", 32'(result), 32'h00FFFA80);

    // T5 handshake hold; start during DONE ignored
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      step();
      check("t5_hold_valid", 32'(result_valid), 32'd1);
      check("t5_hold_result", 32'(result), 32'h00FFFA80);
      check("t5_hold_cs", 32'(cs), 32'hF);
    end
    start = 1'b0;
    result_ready = 1'b1;
    step();
    check("t5_release_valid", 32'(result_valid), 32'd0);
    check("t5_release_busy", 32'(busy), 32'd0);
    check("t5_release_result", 32'(result), 32'h00FFFA80);
    step();
    check("t5_stay_idle", 32'(busy), 32'd0);

    // T4 Tick gating: Tick high every third cycle
    regs = '{8'd1, 8'd2, 8'd3, 8'd4};
    wts  = '{8'd1, 8'd1, 8'd1, 8'd1};
    Tick = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        Tick = (j == 2);
        check("t4_cs", 32'(cs), 32'(cs_exp[k]));
        step();
      end
    end
    Tick = 1'b1;
    check("t4_valid", 32'(result_valid), 32'd1);
    check("t4_result", 32'(result), 32'd10);
    step();
    check("t4_idle", 32'(busy), 32'd0);

    // T6 overflow on the AccBits=17 instance
`ifdef LEA_SCAN_SATURATE_EN
    exp_ovf = 32'h0FFFF;
`else
    exp_ovf = 32'h1FA04;
`endif
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (8) step();
    check("t6_valid", 32'(valid2), 32'd1);
    check("t6_result", 32'(result2), exp_ovf);
    step();
    check("t6_idle", 32'(busy2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
